regfile_wb_scheduler: RTL
=========================

# regfile_wb_scheduler

Write-back scheduler for the 32×32 integer register file. It arbitrates the register file's single write port among several producers (ALU, load/store unit, multi-cycle mul/div) using round-robin order and a valid/ready handshake. It also keeps a per-register busy scoreboard so the issue stage can stall on RAW and WAW hazards. It sits between the execute units and the register file's write port (write enable, write address, write data).

## Interface
- NUM_REQ, 3, number of write-back requesters; index 0 = ALU, 1 = LSU, 2 = mul/div
- XLEN, 32, data width
- NREG, 32, architectural registers; address width fixed at 5 bits
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  requester i has a result ready to write
- req_rd  in  NUM_REQ*5  destination register of requester i, packed, slice i at [5i+4:5i]
- req_data  in  NUM_REQ*XLEN  result data of requester i, packed
- req_ready  out  NUM_REQ  one-hot grant; asserted means requester i's result is accepted this cycle
- rf_we  out  1  register-file write enable, registered
- rf_waddr  out  5  register-file write address, registered
- rf_wdata  out  XLEN  register-file write data, registered
- iss_valid  in  1  issue stage dispatches an instruction this cycle
- iss_rd  in  5  destination register of the dispatched instruction
- chk_rs1  in  5  source register 1 to check
- chk_rs2  in  5  source register 2 to check
- chk_rd  in  5  destination register to check
- hazard  out  1  combinational; 1 if chk_rs1, chk_rs2 or chk_rd is busy
- busy_vec  out  NREG  current scoreboard; bit 0 is always 0

## Operation
- **Handshake.** Requester i holds req_valid, req_rd and req_data stable until it sees req_ready[i]. A transfer happens on a cycle where req_valid[i] and req_ready[i] are both 1.
- **Arbitration.**
  - Round-robin pointer rr_ptr.
  - Search starts at rr_ptr and wraps modulo NUM_REQ. The first requester with valid asserted wins.
  - At most one req_ready bit is set per cycle. req_ready is 0 for any requester whose valid is low.
  - After a grant to index g, rr_ptr becomes (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- **Write port.** A transfer registers rf_we=1, rf_waddr=req_rd[g] and rf_wdata=req_data[g] for the next cycle. With no transfer, rf_we=0 and address/data hold their previous values.
- **Writes to x0.** The requester is still acknowledged, but rf_we is driven 0.
- **Scoreboard.**
  - busy[r] sets on iss_valid with iss_rd=r, for r≠0.
  - busy[r] clears on the cycle the transfer for r is accepted, i.e. at the grant, not at the registered write.
  - If a set and a clear hit the same r in the same cycle, set wins: a new producer has been issued.
  - x0 is never busy.
- **Hazard.** hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd], using current register state. No bypass is implied; a cleared register becomes readable once rf_we commits on the next edge.
- **Requester rule.** A requester may only write back to a register whose busy bit it caused. The block does not check this.

## Timing
- Grant is combinational, in the same cycle as valid.
- Register-file write appears 1 cycle after the transfer and commits at the following edge.
- Back-to-back grants are allowed, one per cycle. With all requesters valid continuously, each is granted once every NUM_REQ cycles.
- Reset, taking effect at the next edge:
  - rr_ptr=0, busy_vec=0
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - req_ready is 0 while rst is high
- Reset asserted mid-operation drops any pending grant. Requesters re-present after reset; in-flight data is discarded.
- hazard follows busy_vec with 0 latency: an issue at cycle t makes hazard visible at cycle t+1.

## Structure
- Shared package (`mathacc_pkg`):
  - REG_ADDR_W=5
  - constants REQ_ALU=0, REQ_LSU=1, REQ_MDU=2
- One sub-module, `rr_arbiter`, parameterized by N: takes request vector and pointer, returns one-hot grant and grant index.
- Scoreboard and write-port registers stay in the top module.

## Test plan
- **Single request.** After reset, req_valid=3'b010, rd=5, data=0xDEADBEEF → req_ready=3'b010 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
- **Round-robin.** All three valid for 6 cycles, rd=1/2/3 → grants 0,1,2,0,1,2 and rf_waddr sequence 1,2,3,1,2,3.
- **Scoreboard.**
  - iss_valid with iss_rd=7 → next cycle busy_vec[7]=1; hazard=1 for chk_rs1=7.
  - LSU writes back rd=7 → busy_vec[7]=0 the cycle after the grant.
- **Same-cycle set and clear.** iss_rd=9 issued in the same cycle as an accepted write-back to rd=9 → busy_vec[9] stays 1.
- **x0 handling.**
  - Write-back to rd=0 → req_ready=1, rf_we stays 0.
  - iss_rd=0 → busy_vec=0.
- **Reset mid-stream.** All requesters valid and busy_vec=0xFFFFFFFE, then rst for 1 cycle → req_ready=0 during reset; afterwards busy_vec=0, rf_we=0, and the first grant goes to requester 0.

Source files
------------

// File: rtl/mathacc_pkg.sv
// Shared constants for the integer-pipeline write-back path.
package mathacc_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_MDU = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps, and the first active request wins.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  int unsigned idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = IW'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the register-file write port among execute units.
// Tracks a per-register busy scoreboard so that issue can stall on RAW and WAW hazards.
module regfile_wb_scheduler
  import mathacc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREG    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]  req_rd,
  input  logic [NUM_REQ*XLEN-1:0]        req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rf_we,
  output logic [REG_ADDR_W-1:0]          rf_waddr,
  output logic [XLEN-1:0]                rf_wdata,
  input  logic                           iss_valid,
  input  logic [REG_ADDR_W-1:0]          iss_rd,
  input  logic [REG_ADDR_W-1:0]          chk_rs1,
  input  logic [REG_ADDR_W-1:0]          chk_rs2,
  input  logic [REG_ADDR_W-1:0]          chk_rd,
  output logic                           hazard,
  output logic [NREG-1:0]                busy_vec
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         ptr_next;
  logic [NUM_REQ-1:0]    gnt;
  logic                  gnt_valid;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // A grant is suppressed during reset so that in-flight data is discarded.
  assign xfer      = gnt_valid & ~rst;
  assign req_ready = rst ? '0 : gnt;
  assign sel_rd    = req_rd[REG_ADDR_W*gnt_idx +: REG_ADDR_W];
  assign sel_data  = req_data[XLEN*gnt_idx +: XLEN];
  assign ptr_next  = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);

  // The clear takes effect at the grant; a same-cycle issue to that register overrides it.
  always_comb begin
    busy_d = busy_q;
    if (xfer)      busy_d[sel_rd] = 1'b0;
    if (iss_valid) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      busy_q   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      busy_q <= busy_d;
      rf_we  <= xfer && (sel_rd != '0);
      if (xfer) begin
        rr_ptr   <= ptr_next;
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

  assign hazard   = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
  assign busy_vec = busy_q;

endmodule
